// File: rtl/axis_mm_ring_pkg.sv
// Shared types and constants for the AXI-stream to DDR ring flow controller.
package axis_mm_ring_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } ring_state_e;

  // Bit positions inside sts_err.
  localparam int unsigned ERR_SPARSE_KEEP = 0;
  localparam int unsigned ERR_BRESP       = 1;
  localparam int unsigned ERR_B_UNDERFLOW = 2;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/axis_mm_ring_ctrl_fifo.sv
// One-bit-wide synchronous FIFO tracking the tlast flag of each beat awaiting a B response.
// Show-ahead read: pop_data is the head entry whenever the FIFO is not empty.
module axis_mm_ring_ctrl_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_q[AW-1:0]];

  // Storage and pointer update; push and pop in one cycle both take effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_data;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/axis_mm_ring_ctrl.sv
// Flow controller for the AXI-stream to AXI write bridge feeding a host circular buffer.
// Generates per-beat ring addresses, gates the stream on ring-full or too many outstanding
// writes, and commits beats / raises irq from the monitored B channel.
// Optional statistics counters are enabled by defining AXIS_MM_RING_CTRL_STATS_EN.
module axis_mm_ring_ctrl
  import axis_mm_ring_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH      = 34,
  parameter int unsigned RING_SIZE_WIDTH = 20,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_enable,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic [4:0]              cfg_size_log2,
  input  logic [RING_SIZE_WIDTH:0] host_rd_ptr,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [ADDR_WIDTH-1:0]   m_axis_addr,
  output logic                    m_axis_addr_valid,
  input  logic                    mon_bvalid,
  input  logic                    mon_bready,
  input  logic [1:0]              mon_bresp,
  output logic [RING_SIZE_WIDTH:0] sts_wr_ptr,
  output logic [RING_SIZE_WIDTH:0] sts_used,
  output logic                    sts_busy,
  output logic [2:0]              sts_err,
  output logic                    irq
`ifdef AXIS_MM_RING_CTRL_STATS_EN
  ,
  output logic [31:0]             sts_pkt_cnt,
  output logic [31:0]             sts_byte_cnt,
  output logic [31:0]             sts_stall_cnt
`endif
);

  localparam int unsigned   PW         = RING_SIZE_WIDTH + 1;
  localparam logic [PW-1:0] BEAT_BYTES = PW'(KEEP_WIDTH);

  ring_state_e           state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [4:0]            size_log2_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         cwr_ptr_q;
  logic                  in_pkt_q;
  logic                  irq_q;
  logic [2:0]            err_q;

  logic [PW-1:0] ring_bytes;
  logic [PW-1:0] offset;
  logic [PW-1:0] used;
  logic          space;
  logic          accept;
  logic          beat;
  logic          resp;
  logic          pop;
  logic          start;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;

  assign ring_bytes = PW'(1) << size_log2_q;
  assign offset     = wr_ptr_q & (ring_bytes - PW'(1));
  assign used       = wr_ptr_q - host_rd_ptr;
  // Room for one more whole beat without overrunning the host read pointer.
  assign space      = (used <= ring_bytes - BEAT_BYTES);
  assign accept     = ((state_q == StRun) || ((state_q == StDrain) && in_pkt_q)) &&
                      space && !fifo_full;

  assign m_axis_tvalid     = s_axis_tvalid & accept;
  assign s_axis_tready     = m_axis_tready & accept;
  assign m_axis_addr_valid = m_axis_tvalid;
  assign m_axis_addr       = base_q + ADDR_WIDTH'(offset);
  assign m_axis_tdata      = s_axis_tdata;
  assign m_axis_tkeep      = s_axis_tkeep;
  assign m_axis_tlast      = s_axis_tlast;

  assign beat  = s_axis_tvalid & s_axis_tready;
  assign resp  = mon_bvalid & mon_bready;
  // A response with nothing outstanding is flagged but never popped.
  assign pop   = resp & !fifo_empty;
  assign start = (state_q == StIdle) && cfg_enable;

  assign sts_wr_ptr = cwr_ptr_q;
  assign sts_used   = used;
  assign sts_busy   = (state_q != StIdle);
  assign sts_err    = err_q;
  assign irq        = irq_q;

  axis_mm_ring_ctrl_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (beat),
    .push_data(s_axis_tlast),
    .pop      (pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Run/drain sequencing, pointer advance, sticky errors and the irq pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      size_log2_q <= '0;
      wr_ptr_q    <= '0;
      cwr_ptr_q   <= '0;
      in_pkt_q    <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= '0;
    end else begin
      irq_q <= pop && fifo_head;
      if (beat) begin
        wr_ptr_q <= wr_ptr_q + BEAT_BYTES;
        in_pkt_q <= !s_axis_tlast;
      end
      if (pop) begin
        cwr_ptr_q <= cwr_ptr_q + BEAT_BYTES;
      end
      if (beat && !s_axis_tlast && (s_axis_tkeep != '1)) begin
        err_q[ERR_SPARSE_KEEP] <= 1'b1;
      end
      if (resp && (mon_bresp != BRESP_OKAY)) begin
        err_q[ERR_BRESP] <= 1'b1;
      end
      if (resp && fifo_empty) begin
        err_q[ERR_B_UNDERFLOW] <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (cfg_enable) begin
            state_q     <= StRun;
            base_q      <= cfg_base_addr;
            size_log2_q <= cfg_size_log2;
            wr_ptr_q    <= '0;
            cwr_ptr_q   <= '0;
            err_q       <= '0;
          end
        end
        StRun: begin
          if (!cfg_enable) state_q <= StDrain;
        end
        StDrain: begin
          // Re-enable is ignored here; only a full drain returns to idle.
          if (!in_pkt_q && fifo_empty) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef AXIS_MM_RING_CTRL_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] byte_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] keep_bytes;

  // Number of valid bytes in the presented beat.
  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_bytes = keep_bytes + 32'(s_axis_tkeep[i]);
    end
  end

  // Saturating statistics, restarted with every run.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && fifo_head)         pkt_cnt_q   <= sat_add32(pkt_cnt_q, 32'd1);
      if (beat)                     byte_cnt_q  <= sat_add32(byte_cnt_q, keep_bytes);
      if (s_axis_tvalid && !accept) stall_cnt_q <= sat_add32(stall_cnt_q, 32'd1);
    end
  end

  assign sts_pkt_cnt   = pkt_cnt_q;
  assign sts_byte_cnt  = byte_cnt_q;
  assign sts_stall_cnt = stall_cnt_q;
`endif

endmodule
